// File: rtl/alu_mul_sequencer.sv
// Shift-add multiplier sequencer that borrows the shared ALU adder through a request/grant pair.
// Produces the low WIDTH bits of op_a*op_b, terminating as soon as the multiplier runs out of ones.
module alu_mul_sequencer #(
  parameter int unsigned WIDTH   = 32,
  parameter logic [3:0]  ADD_CTL = 4'd2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_alu_req,
  input  logic             i_alu_grant,
  output logic [3:0]       o_alu_ctl,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  input  logic [WIDTH-1:0] i_alu_out
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_result;
  logic             r_busy;
  logic             r_done;

  logic             w_mplier_zero;

  assign w_mplier_zero = (r_mplier == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_acc    <= '0;
            r_mcand  <= i_op_a;
            r_mplier <= i_op_b;
            r_state  <= StRun;
            r_busy   <= 1'b1;
          end
        end
        StRun: begin
          if (w_mplier_zero) begin
            r_result <= r_acc;
            r_state  <= StDone;
            r_done   <= 1'b1;
          end else if (i_alu_grant) begin
            // The ALU always computes acc + mcand; only commit it when this multiplier bit is set.
            if (r_mplier[0]) begin
              r_acc <= i_alu_out;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Request depends on registers only, so the arbiter never sees a loop through grant.
  assign o_alu_req = (r_state == StRun) && !w_mplier_zero;
  assign o_alu_ctl = ADD_CTL;
  assign o_alu_a   = r_acc;
  assign o_alu_b   = r_mcand;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_result  = r_result;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Randomized and directed bench for alu_mul_sequencer; the ALU adder is modelled here and the
// expected product and timing come from plain arithmetic on the operands.
module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        alu_req;
  logic        grant;
  logic [3:0]  alu_ctl;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign alu_out = alu_a + alu_b;

  alu_mul_sequencer #(
    .WIDTH  (32),
    .ADD_CTL(4'd2)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_op_a     (op_a),
    .i_op_b     (op_b),
    .o_busy     (busy),
    .o_done     (done),
    .o_result   (result),
    .o_alu_req  (alu_req),
    .i_alu_grant(grant),
    .o_alu_ctl  (alu_ctl),
    .o_alu_a    (alu_a),
    .o_alu_b    (alu_b),
    .i_alu_out  (alu_out)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  function automatic int bitlen(input logic [31:0] v);
    int n = 0;
    for (int i = 0; i < 32; i++) if (v[i]) n = i + 1;
    return n;
  endfunction

  // Accepts one operation at cycle 0 and records what the DUT shows; mode 2 randomizes grant.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int mode,
                        output int done_cyc, output logic [31:0] res, output int req_cnt,
                        output int stalls, output int busy_fall, output int ctl_bad);
    done_cyc  = -1;
    res       = '0;
    req_cnt   = 0;
    stalls    = 0;
    busy_fall = -1;
    ctl_bad   = 0;
    op_a      = a;
    op_b      = b;
    start     = 1'b1;
    grant     = 1'b1;
    next_cycle();
    start = 1'b0;
    for (int c = 1; c < 200; c++) begin
      grant = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      sample();
      if (alu_req === 1'b1) begin
        req_cnt++;
        if (!grant) stalls++;
        if (alu_ctl !== 4'd2) ctl_bad++;
      end
      if (done === 1'b1 && done_cyc < 0) begin
        done_cyc = c;
        res      = result;
      end else if (done_cyc >= 0 && busy === 1'b0) begin
        busy_fall = c;
        break;
      end
      next_cycle();
    end
    next_cycle();
    grant = 1'b1;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    grant = 1'b1;
    op_a  = '0;
    op_b  = '0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    sample();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++;
    if (result !== 32'd0) begin bad++; $display("FAIL reset_result: got %0h want 0", result); end
    total++;
    if (alu_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", alu_req); end
    next_cycle();
  endtask

  task automatic test_directed(input string name, input logic [31:0] a, input logic [31:0] b,
                               input int exp_done, input logic [31:0] exp_res, input int exp_req);
    int dc, rc, st, bf, cb;
    logic [31:0] r;
    run_op(a, b, 0, dc, r, rc, st, bf, cb);
    total++;
    if (dc != exp_done) begin bad++; $display("FAIL %s_done_cycle: got %0d want %0d", name, dc, exp_done); end
    total++;
    if (r !== exp_res) begin bad++; $display("FAIL %s_result: got %0h want %0h", name, r, exp_res); end
    total++;
    if (rc != exp_req) begin bad++; $display("FAIL %s_req_cycles: got %0d want %0d", name, rc, exp_req); end
    total++;
    if (bf != exp_done + 1) begin bad++; $display("FAIL %s_busy_fall: got %0d want %0d", name, bf, exp_done + 1); end
  endtask

  task automatic test_stall();
    logic [31:0] a1, b1;
    int dc = -1;
    op_a  = 32'd5;
    op_b  = 32'd5;
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    grant = 1'b0;
    sample();
    a1 = alu_a;
    b1 = alu_b;
    total++; if (alu_req !== 1'b1) begin bad++; $display("FAIL stall_req_c1: got %b want 1", alu_req); end
    total++;
    if (a1 !== 32'd0 || b1 !== 32'd5) begin
      bad++; $display("FAIL stall_regs_c1: got %0h/%0h want 0/5", a1, b1);
    end
    next_cycle();
    sample();
    total++; if (alu_req !== 1'b1) begin bad++; $display("FAIL stall_req_c2: got %b want 1", alu_req); end
    total++;
    if (alu_a !== a1 || alu_b !== b1) begin
      bad++; $display("FAIL stall_hold_c2: got %0h/%0h want %0h/%0h", alu_a, alu_b, a1, b1);
    end
    next_cycle();
    grant = 1'b1;
    for (int c = 3; c < 40; c++) begin
      sample();
      if (done === 1'b1) begin
        dc = c;
        break;
      end
      next_cycle();
    end
    total++; if (dc != 7) begin bad++; $display("FAIL stall_done_cycle: got %0d want 7", dc); end
    total++;
    if (result !== 32'd25) begin bad++; $display("FAIL stall_result: got %0h want 19", result); end
    next_cycle();
    next_cycle();
  endtask

  task automatic test_start_busy();
    op_a  = 32'd3;
    op_b  = 32'd6;
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    op_a  = 32'd9;
    op_b  = 32'd9;
    next_cycle();
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    next_cycle();
    next_cycle();
    start = 1'b1;
    sample();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL busy_start_done: got %b want 1", done); end
    total++;
    if (result !== 32'd18) begin bad++; $display("FAIL busy_start_result: got %0d want 18", result); end
    next_cycle();
    start = 1'b0;
    sample();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_start_c6: got %b want 0", busy); end
    next_cycle();
    sample();
    total++;
    if (busy !== 1'b0 || alu_req !== 1'b0) begin
      bad++; $display("FAIL busy_start_c7: got busy=%b req=%b want 0/0", busy, alu_req);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    op_a  = 32'd7;
    op_b  = 32'hFF;
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    next_cycle();
    next_cycle();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    sample();
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || alu_req !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_state: got busy=%b done=%b result=%0h req=%b want 0/0/0/0",
               busy, done, result, alu_req);
    end
    for (int c = 0; c < 20; c++) begin
      next_cycle();
      sample();
      if (done === 1'b1) dones++;
    end
    total++; if (dones != 0) begin bad++; $display("FAIL reset_mid_no_done: got %0d want 0", dones); end
    next_cycle();
    test_directed("after_reset", 32'd2, 32'd3, 4, 32'd6, 2);
  endtask

  task automatic test_random();
    int dc, rc, st, bf, cb, k;
    logic [31:0] a, b, r, expv;
    for (int n = 0; n < 30; n++) begin
      a = $urandom;
      b = (n % 7 == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      expv = a * b;
      k = bitlen(b);
      run_op(a, b, 2, dc, r, rc, st, bf, cb);
      total++;
      if (r !== expv) begin bad++; $display("FAIL rand_result %0h*%0h: got %0h want %0h", a, b, r, expv); end
      total++;
      if (dc != k + 2 + st) begin bad++; $display("FAIL rand_done_cycle: got %0d want %0d", dc, k + 2 + st); end
      total++;
      if (rc != k + st) begin bad++; $display("FAIL rand_req_cycles: got %0d want %0d", rc, k + st); end
      total++;
      if (bf != dc + 1) begin bad++; $display("FAIL rand_busy_fall: got %0d want %0d", bf, dc + 1); end
      total++;
      if (cb != 0) begin bad++; $display("FAIL rand_alu_ctl: got %0d bad cycles want 0", cb); end
    end
  endtask

  initial begin
    test_reset();
    test_directed("basic", 32'd5, 32'd5, 5, 32'd25, 3);
    test_directed("zero", 32'h1234, 32'd0, 2, 32'd0, 0);
    test_directed("wrap", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'd1, 32);
    test_directed("signed", 32'hFFFF_FFFD, 32'd7, 5, 32'hFFFF_FFEB, 3);
    test_stall();
    test_start_busy();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
